output_port_alloc: RTL and testbench

- Per-output-port allocator: the responder side of the router's route-computation request vector.
- Each input port drives its one-hot request bit for this output. The block arbitrates round-robin, locks the output to the winner for a whole wormhole packet (head through tail), and gates flit transfer on link_up and downstream credits.
- One instance per output port (N, S, E, W, NE, NW, SE, SW, SER_N/S/E/W).

---
 rtl/output_port_alloc.sv | 129 ++++++++++++
 tb/tb_output_port_alloc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/output_port_alloc.sv
// Per-output-port allocator: round-robin arbitration, wormhole lock head..tail, credit/link gated flit transfer.
// Latency: request at t -> registered grant at t+1 (earliest xfer t+1); tail xfer at k -> idle at k+1, next grant k+2.
// Backpressure: xfer stalls (lock held) while link_up=0 or credits=0; non-owners see grant=0 and must hold flits.
module output_port_alloc #(
   parameter int N_IN        = 12,
   parameter int MAX_CREDITS = 4,
   parameter int CREDIT_W    = 3,
   parameter int IDX_W       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_IN-1:0]     req,
   input  logic [N_IN-1:0]     flit_valid,
   input  logic [N_IN-1:0]     flit_tail,
   input  logic                link_up,
   input  logic                credit_ret,
   output logic [N_IN-1:0]     grant,
   output logic [IDX_W-1:0]    owner,
   output logic                busy,
   output logic                xfer,
   output logic [CREDIT_W-1:0] credits,
   output logic                credit_err
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(MAX_CREDITS);
   localparam logic [N_IN-1:0]     ONE_HOT0 = {{(N_IN-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [N_IN-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic                credit_err_q, credit_err_d;

   logic [N_IN-1:0]     cand;
   logic                found;
   logic [IDX_W-1:0]    win;
   int                  idx;

   assign cand       = req & flit_valid;
   assign xfer       = (state_q == LOCKED) && flit_valid[owner_q] && link_up && (credits_q != '0);
   assign grant      = grant_q;
   assign owner      = owner_q;
   assign busy       = (state_q == LOCKED);
   assign credits    = credits_q;
   assign credit_err = credit_err_q;

   // Round-robin pick: first candidate after rr_ptr, wrapping modulo N_IN.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int off = 1; off <= N_IN; off++) begin
         idx = int'(rr_ptr_q) + off;
         if (idx >= N_IN) idx = idx - N_IN;
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = IDX_W'(idx);
         end
      end
   end

   // Lock FSM: grant on a transferable request, release after the owner's tail moves.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            if (found && link_up && (credits_q != '0)) begin
               state_d = LOCKED;
               grant_d = ONE_HOT0 << win;
               owner_d = win;
            end
         end
         LOCKED: begin
            if (xfer && flit_tail[owner_q]) begin
               state_d  = IDLE;
               grant_d  = '0;
               owner_d  = '0;
               rr_ptr_d = owner_q;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
         end
      endcase
   end

   // Downstream credit counter; a return with the counter already full is flagged, not counted.
   always_comb begin
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      unique case ({xfer, credit_ret})
         2'b10:   credits_d = credits_q - 1'b1;
         2'b01: begin
            if (credits_q == CRED_MAX) credit_err_d = 1'b1;
            else                       credits_d    = credits_q + 1'b1;
         end
         default: credits_d = credits_q;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         rr_ptr_q     <= IDX_W'(N_IN - 1);
         credits_q    <= CRED_MAX;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
      end
   end

endmodule

// File: tb/tb_output_port_alloc.sv
// Directed-vector bench for output_port_alloc: each vector drives one cycle of inputs
// and compares grant/owner/busy/xfer/credits/credit_err mid-cycle against hand-computed values.
// Inputs change 1ns after the rising edge; outputs are sampled 3ns after the edge.
module tb_output_port_alloc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] req = '0;
   logic [11:0] flit_valid = '0;
   logic [11:0] flit_tail = '0;
   logic        link_up = 1'b0;
   logic        credit_ret = 1'b0;
   logic [11:0] grant;
   logic [3:0]  owner;
   logic        busy;
   logic        xfer;
   logic [2:0]  credits;
   logic        credit_err;

   int n_vec = 0;
   int n_err = 0;

   output_port_alloc #(.N_IN(12), .MAX_CREDITS(4), .CREDIT_W(3), .IDX_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .flit_valid (flit_valid),
      .flit_tail  (flit_tail),
      .link_up    (link_up),
      .credit_ret (credit_ret),
      .grant      (grant),
      .owner      (owner),
      .busy       (busy),
      .xfer       (xfer),
      .credits    (credits),
      .credit_err (credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] idx_of(input logic [11:0] g);
      logic [3:0] r = '0;
      for (int i = 0; i < 12; i++) if (g[i]) r = 4'(i);
      return r;
   endfunction

   // One cycle: drive inputs, check outputs mid-cycle, advance past the next rising edge.
   task automatic apply(input string tag,
                        input logic [11:0] r, input logic [11:0] fv, input logic [11:0] t,
                        input logic l, input logic cr,
                        input logic [11:0] eg, input logic ex, input logic [2:0] ec,
                        input logic ee);
      req = r; flit_valid = fv; flit_tail = t; link_up = l; credit_ret = cr;
      #2;
      chk({tag, ".grant"},   32'(grant),      32'(eg));
      chk({tag, ".owner"},   32'(owner),      32'(idx_of(eg)));
      chk({tag, ".busy"},    32'(busy),       32'(eg != 12'h0));
      chk({tag, ".xfer"},    32'(xfer),       32'(ex));
      chk({tag, ".credits"}, 32'(credits),    32'(ec));
      chk({tag, ".err"},     32'(credit_err), 32'(ee));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      req = '0; flit_valid = '0; flit_tail = '0; link_up = 1'b0; credit_ret = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      #2;
      chk("rst.grant",   32'(grant),      32'h0);
      chk("rst.owner",   32'(owner),      32'h0);
      chk("rst.busy",    32'(busy),       32'h0);
      chk("rst.xfer",    32'(xfer),       32'h0);
      chk("rst.credits", 32'(credits),    32'h4);
      chk("rst.err",     32'(credit_err), 32'h0);
      @(posedge clk); #1;

      // Single requester, single-flit packet; then inputs 1 and 3 show rr_ptr moved to 2.
      apply("single.c0", 12'h004, 12'h004, 12'h004, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("single.c1", 12'h004, 12'h004, 12'h004, 1, 0, 12'h004, 1, 3'd4, 0);
      apply("single.c2", 12'h00A, 12'h00A, 12'h00A, 1, 0, 12'h000, 0, 3'd3, 0);
      apply("single.c3", 12'h00A, 12'h00A, 12'h00A, 1, 0, 12'h008, 1, 3'd3, 0);
      apply("single.c4", 12'h00A, 12'h00A, 12'h00A, 1, 0, 12'h000, 0, 3'd2, 0);
      apply("single.c5", 12'h000, 12'h002, 12'h002, 1, 0, 12'h002, 1, 3'd2, 0);
      apply("single.c6", 12'h000, 12'h000, 12'h000, 1, 0, 12'h000, 0, 3'd1, 0);

      // Round-robin among 1, 5, 9 with a credit returned on every transfer.
      do_reset();
      apply("rr.c0", 12'h222, 12'h222, 12'h222, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("rr.c1", 12'h222, 12'h222, 12'h222, 1, 1, 12'h002, 1, 3'd4, 0);
      apply("rr.c2", 12'h222, 12'h222, 12'h222, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("rr.c3", 12'h222, 12'h222, 12'h222, 1, 1, 12'h020, 1, 3'd4, 0);
      apply("rr.c4", 12'h222, 12'h222, 12'h222, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("rr.c5", 12'h222, 12'h222, 12'h222, 1, 1, 12'h200, 1, 3'd4, 0);
      apply("rr.c6", 12'h222, 12'h222, 12'h222, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("rr.c7", 12'h222, 12'h222, 12'h222, 1, 1, 12'h002, 1, 3'd4, 0);

      // Wormhole: input 3 sends 4 flits while input 0 requests from the second cycle on.
      do_reset();
      apply("worm.c0", 12'h008, 12'h008, 12'h000, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("worm.c1", 12'h009, 12'h009, 12'h001, 1, 1, 12'h008, 1, 3'd4, 0);
      apply("worm.c2", 12'h009, 12'h009, 12'h001, 1, 1, 12'h008, 1, 3'd4, 0);
      apply("worm.c3", 12'h009, 12'h009, 12'h001, 1, 1, 12'h008, 1, 3'd4, 0);
      apply("worm.c4", 12'h009, 12'h009, 12'h009, 1, 1, 12'h008, 1, 3'd4, 0);
      apply("worm.c5", 12'h001, 12'h001, 12'h001, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("worm.c6", 12'h001, 12'h001, 12'h001, 1, 1, 12'h001, 1, 3'd4, 0);
      apply("worm.c7", 12'h000, 12'h000, 12'h000, 1, 0, 12'h000, 0, 3'd4, 0);

      // Credit stall: 6-flit packet from input 7, credits exhausted, lock held.
      do_reset();
      apply("stall.c0",  12'h080, 12'h080, 12'h000, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("stall.c1",  12'h080, 12'h080, 12'h000, 1, 0, 12'h080, 1, 3'd4, 0);
      apply("stall.c2",  12'h080, 12'h080, 12'h000, 1, 0, 12'h080, 1, 3'd3, 0);
      apply("stall.c3",  12'h080, 12'h080, 12'h000, 1, 0, 12'h080, 1, 3'd2, 0);
      apply("stall.c4",  12'h080, 12'h080, 12'h000, 1, 0, 12'h080, 1, 3'd1, 0);
      apply("stall.c5",  12'h080, 12'h080, 12'h000, 1, 0, 12'h080, 0, 3'd0, 0);
      apply("stall.c6",  12'h080, 12'h080, 12'h000, 1, 1, 12'h080, 0, 3'd0, 0);
      apply("stall.c7",  12'h080, 12'h080, 12'h000, 1, 0, 12'h080, 1, 3'd1, 0);
      apply("stall.c8",  12'h080, 12'h080, 12'h000, 1, 1, 12'h080, 0, 3'd0, 0);
      apply("stall.c9",  12'h080, 12'h080, 12'h080, 1, 1, 12'h080, 1, 3'd1, 0);
      apply("stall.c10", 12'h000, 12'h000, 12'h000, 1, 0, 12'h000, 0, 3'd1, 0);

      // Link down mid-packet, then link down while idle with a request pending.
      do_reset();
      apply("link.c0", 12'h010, 12'h010, 12'h000, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("link.c1", 12'h010, 12'h010, 12'h000, 1, 1, 12'h010, 1, 3'd4, 0);
      apply("link.c2", 12'h010, 12'h010, 12'h000, 0, 0, 12'h010, 0, 3'd4, 0);
      apply("link.c3", 12'h010, 12'h010, 12'h010, 1, 1, 12'h010, 1, 3'd4, 0);
      apply("link.c4", 12'h010, 12'h010, 12'h010, 0, 0, 12'h000, 0, 3'd4, 0);
      apply("link.c5", 12'h010, 12'h010, 12'h010, 0, 0, 12'h000, 0, 3'd4, 0);
      apply("link.c6", 12'h010, 12'h010, 12'h010, 1, 0, 12'h000, 0, 3'd4, 0);
      apply("link.c7", 12'h000, 12'h010, 12'h010, 1, 1, 12'h010, 1, 3'd4, 0);
      apply("link.c8", 12'h000, 12'h000, 12'h000, 1, 0, 12'h000, 0, 3'd4, 0);

      // Overflowing credit return is sticky; asynchronous reset mid-packet clears everything.
      do_reset();
      apply("err.c0", 12'h000, 12'h000, 12'h000, 1, 1, 12'h000, 0, 3'd4, 0);
      apply("err.c1", 12'h004, 12'h004, 12'h000, 1, 0, 12'h000, 0, 3'd4, 1);
      apply("err.c2", 12'h004, 12'h004, 12'h000, 1, 0, 12'h004, 1, 3'd4, 1);
      #1;
      chk("arst.pre_credits", 32'(credits), 32'h3);
      chk("arst.pre_grant",   32'(grant),   32'h004);
      rst = 1'b1;
      #1;
      chk("arst.grant",   32'(grant),      32'h0);
      chk("arst.owner",   32'(owner),      32'h0);
      chk("arst.busy",    32'(busy),       32'h0);
      chk("arst.xfer",    32'(xfer),       32'h0);
      chk("arst.credits", 32'(credits),    32'h4);
      chk("arst.err",     32'(credit_err), 32'h0);
      req = '0; flit_valid = '0; flit_tail = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
